// File: rtl/bufrot_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : bufrot_ctrl                                                      |
// | Purpose  : Rotates ping/pang/pung buffers through snooper, CPU filter and   |
// |            forwarder in strict packet order; tracks per-buffer length.      |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
module bufrot_ctrl #(
    parameter int LEN_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sn_done,
    input  logic [LEN_WIDTH-1:0] sn_len,
    input  logic                 cpu_acc,
    input  logic                 cpu_rej,
    input  logic                 fwd_done,
    output logic [1:0]           sn_sel,
    output logic [1:0]           cpu_sel,
    output logic [1:0]           fwd_sel,
    output logic                 sn_rdy,
    output logic                 cpu_rdy,
    output logic                 fwd_rdy,
    output logic [LEN_WIDTH-1:0] cpu_len,
    output logic [LEN_WIDTH-1:0] fwd_len
);

    typedef enum logic [2:0] {
        ST_EMPTY    = 3'd0,
        ST_SN       = 3'd1,
        ST_CPU_WAIT = 3'd2,
        ST_CPU      = 3'd3,
        ST_FWD_WAIT = 3'd4,
        ST_FWD      = 3'd5
    } buf_state_e;

    localparam logic [1:0] C_PING = 2'b01;

    buf_state_e           bstate_q [3];
    buf_state_e           bstate_d [3];
    logic [LEN_WIDTH-1:0] blen_q   [3];
    logic [LEN_WIDTH-1:0] blen_d   [3];
    logic [2:0]           drop_q, drop_d;
    logic [1:0]           sn_ptr_q, sn_ptr_d, cpu_ptr_q, cpu_ptr_d, fwd_ptr_q, fwd_ptr_d;
    logic [1:0]           sn_sel_q, sn_sel_d, cpu_sel_q, cpu_sel_d, fwd_sel_q, fwd_sel_d;
    logic                 sn_rdy_q, sn_rdy_d, cpu_rdy_q, cpu_rdy_d, fwd_rdy_q, fwd_rdy_d;
    logic [LEN_WIDTH-1:0] cpu_len_q, cpu_len_d, fwd_len_q, fwd_len_d;
    logic                 start_q, start_d;
    logic [1:0]           sn_idx, cpu_idx, fwd_idx;

    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        case (p)
            2'b01:   ptr_next = 2'b10;
            2'b10:   ptr_next = 2'b11;
            default: ptr_next = 2'b01;
        endcase
    endfunction

    // Pointers hold 01..11, so subtracting one gives the buffer array index.
    assign sn_idx  = sn_ptr_q  - 2'd1;
    assign cpu_idx = cpu_ptr_q - 2'd1;
    assign fwd_idx = fwd_ptr_q - 2'd1;

    always_comb begin
        bstate_d  = bstate_q;
        blen_d    = blen_q;
        drop_d    = drop_q;
        sn_ptr_d  = sn_ptr_q;
        cpu_ptr_d = cpu_ptr_q;
        fwd_ptr_d = fwd_ptr_q;
        sn_sel_d  = sn_sel_q;
        cpu_sel_d = cpu_sel_q;
        fwd_sel_d = fwd_sel_q;
        sn_rdy_d  = sn_rdy_q;
        cpu_rdy_d = cpu_rdy_q;
        fwd_rdy_d = fwd_rdy_q;
        cpu_len_d = cpu_len_q;
        fwd_len_d = fwd_len_q;
        start_d   = 1'b1;

        // Snooper: a zero-length packet frees the buffer without advancing.
        if (sn_rdy_q) begin
            if (sn_done) begin
                sn_sel_d = 2'b00;
                sn_rdy_d = 1'b0;
                if (sn_len == '0) begin
                    bstate_d[sn_idx] = ST_EMPTY;
                end else begin
                    bstate_d[sn_idx] = ST_CPU_WAIT;
                    blen_d[sn_idx]   = sn_len;
                    sn_ptr_d         = ptr_next(sn_ptr_q);
                end
            end
        end else if (start_q && bstate_q[sn_idx] == ST_EMPTY) begin
            bstate_d[sn_idx] = ST_SN;
            sn_sel_d         = sn_ptr_q;
            sn_rdy_d         = 1'b1;
        end

        // CPU: reject takes priority over accept.
        if (cpu_rdy_q) begin
            if (cpu_rej || cpu_acc) begin
                bstate_d[cpu_idx] = ST_FWD_WAIT;
                drop_d[cpu_idx]   = cpu_rej;
                cpu_sel_d         = 2'b00;
                cpu_rdy_d         = 1'b0;
                cpu_len_d         = '0;
                cpu_ptr_d         = ptr_next(cpu_ptr_q);
            end
        end else if (start_q && bstate_q[cpu_idx] == ST_CPU_WAIT) begin
            bstate_d[cpu_idx] = ST_CPU;
            cpu_sel_d         = cpu_ptr_q;
            cpu_rdy_d         = 1'b1;
            cpu_len_d         = blen_q[cpu_idx];
        end

        // Forwarder: dropped buffers are retired in place so order is kept.
        if (fwd_rdy_q) begin
            if (fwd_done) begin
                bstate_d[fwd_idx] = ST_EMPTY;
                fwd_sel_d         = 2'b00;
                fwd_rdy_d         = 1'b0;
                fwd_len_d         = '0;
                fwd_ptr_d         = ptr_next(fwd_ptr_q);
            end
        end else if (start_q && bstate_q[fwd_idx] == ST_FWD_WAIT) begin
            if (drop_q[fwd_idx]) begin
                bstate_d[fwd_idx] = ST_EMPTY;
                drop_d[fwd_idx]   = 1'b0;
                fwd_ptr_d         = ptr_next(fwd_ptr_q);
            end else begin
                bstate_d[fwd_idx] = ST_FWD;
                fwd_sel_d         = fwd_ptr_q;
                fwd_rdy_d         = 1'b1;
                fwd_len_d         = blen_q[fwd_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                bstate_q[i] <= ST_EMPTY;
                blen_q[i]   <= '0;
            end
            drop_q    <= 3'b000;
            sn_ptr_q  <= C_PING;
            cpu_ptr_q <= C_PING;
            fwd_ptr_q <= C_PING;
            sn_sel_q  <= 2'b00;
            cpu_sel_q <= 2'b00;
            fwd_sel_q <= 2'b00;
            sn_rdy_q  <= 1'b0;
            cpu_rdy_q <= 1'b0;
            fwd_rdy_q <= 1'b0;
            cpu_len_q <= '0;
            fwd_len_q <= '0;
            start_q   <= 1'b0;
        end else begin
            bstate_q  <= bstate_d;
            blen_q    <= blen_d;
            drop_q    <= drop_d;
            sn_ptr_q  <= sn_ptr_d;
            cpu_ptr_q <= cpu_ptr_d;
            fwd_ptr_q <= fwd_ptr_d;
            sn_sel_q  <= sn_sel_d;
            cpu_sel_q <= cpu_sel_d;
            fwd_sel_q <= fwd_sel_d;
            sn_rdy_q  <= sn_rdy_d;
            cpu_rdy_q <= cpu_rdy_d;
            fwd_rdy_q <= fwd_rdy_d;
            cpu_len_q <= cpu_len_d;
            fwd_len_q <= fwd_len_d;
            start_q   <= start_d;
        end
    end

    assign sn_sel  = sn_sel_q;
    assign cpu_sel = cpu_sel_q;
    assign fwd_sel = fwd_sel_q;
    assign sn_rdy  = sn_rdy_q;
    assign cpu_rdy = cpu_rdy_q;
    assign fwd_rdy = fwd_rdy_q;
    assign cpu_len = cpu_len_q;
    assign fwd_len = fwd_len_q;

endmodule
`default_nettype wire
